// File: rtl/mem_ddr_load_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ddr_load_ctrl
//
// Sequences one DDR->SRAM bulk load. A byte-length transfer is split into
// whole lines (NUM_WORDS_IN_LINE bytes each). One DDR line read is issued at
// a time, and the returned line is presented to the SRAM write port together
// with a byte mask until the arbiter acknowledges it. At most one line is in
// flight. Only the final line can carry a partial mask.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start          1-cycle request, sampled only while idle
//   ddr_addr       DDR byte start address (line aligned), latched on start
//   sram_addr      SRAM byte start address (line aligned), latched on start
//   len_bytes      transfer length in bytes, latched on start
//   abort          cancels the transfer in progress (ignored while idle)
//   busy           high from the cycle after start until the controller is idle again
//   done           1-cycle pulse after the last line is acked (or for a zero length)
//   ddr_req        1-cycle read request; ddr_req_addr carries the line address
//   ddr_valid      returned line valid, ddr_data carries the line
//   sram_wr        write request, held with addr/data/mask until sram_ack
//   sram_wr_addr   SRAM line address
//   sram_wr_data   registered line data
//   sram_wr_mask   byte enables, bit i enables byte i
//   sram_ack       write accepted by the arbiter
// ---------------------------------------------------------------------------
module mem_ddr_load_ctrl #(
    parameter int WORD_WIDTH        = 8,
    parameter int NUM_WORDS_IN_LINE = 32,
    parameter int ADDR_WIDTH        = 19,
    parameter int LEN_WIDTH         = 16
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic [31:0]                             ddr_addr,
    input  logic [ADDR_WIDTH-1:0]                   sram_addr,
    input  logic [LEN_WIDTH-1:0]                    len_bytes,
    input  logic                                    abort,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    ddr_req,
    output logic [31:0]                             ddr_req_addr,
    input  logic                                    ddr_valid,
    input  logic [WORD_WIDTH*NUM_WORDS_IN_LINE-1:0] ddr_data,
    output logic                                    sram_wr,
    output logic [ADDR_WIDTH-1:0]                   sram_wr_addr,
    output logic [WORD_WIDTH*NUM_WORDS_IN_LINE-1:0] sram_wr_data,
    output logic [NUM_WORDS_IN_LINE-1:0]            sram_wr_mask,
    input  logic                                    sram_ack
);

    localparam int LINE_W = WORD_WIDTH * NUM_WORDS_IN_LINE;
    localparam int OFF_W  = $clog2(NUM_WORDS_IN_LINE);
    localparam int CNT_W  = LEN_WIDTH - OFF_W + 1;

    localparam logic [31:0]                  DDR_STEP   = 32'(NUM_WORDS_IN_LINE);
    localparam logic [ADDR_WIDTH-1:0]        SRAM_STEP  = ADDR_WIDTH'(NUM_WORDS_IN_LINE);
    localparam logic [CNT_W-1:0]             CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]             CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [OFF_W-1:0]             OFF_ZERO   = {OFF_W{1'b0}};
    localparam logic [LINE_W-1:0]            LINE_ZERO  = {LINE_W{1'b0}};
    localparam logic [NUM_WORDS_IN_LINE-1:0] MASK_ZERO  = {NUM_WORDS_IN_LINE{1'b0}};
    localparam logic [NUM_WORDS_IN_LINE-1:0] MASK_ONES  = {NUM_WORDS_IN_LINE{1'b1}};
    localparam logic [ADDR_WIDTH-1:0]        SADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]         LEN_ZERO   = {LEN_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Byte mask for the final line: the low 'rem' bytes, or the full line when
    // the length is an exact multiple of the line size.
    function automatic logic [NUM_WORDS_IN_LINE-1:0] tail_mask(input logic [OFF_W-1:0] rem);
        logic [NUM_WORDS_IN_LINE-1:0] m;
        for (int i = 0; i < NUM_WORDS_IN_LINE; i++) begin
            m[i] = (rem == OFF_ZERO) || (i < int'(rem));
        end
        return m;
    endfunction

    state_t                       state_q, state_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         ddr_req_q, ddr_req_d;
    logic [31:0]                  ddr_req_addr_q, ddr_req_addr_d;
    logic                         sram_wr_q, sram_wr_d;
    logic [ADDR_WIDTH-1:0]        sram_wr_addr_q, sram_wr_addr_d;
    logic [LINE_W-1:0]            sram_wr_data_q, sram_wr_data_d;
    logic [NUM_WORDS_IN_LINE-1:0] sram_wr_mask_q, sram_wr_mask_d;
    // Current line addresses, lines still to write (including the current one)
    // and the byte remainder that shapes the last line's mask.
    logic [31:0]                  cur_ddr_q, cur_ddr_d;
    logic [ADDR_WIDTH-1:0]        cur_sram_q, cur_sram_d;
    logic [CNT_W-1:0]             lines_q, lines_d;
    logic [OFF_W-1:0]             rem_q, rem_d;

    logic [CNT_W-1:0]             start_lines_s;
    logic                         last_line_s;

    // Line count of the requested transfer, rounded up to whole lines.
    always_comb begin
        start_lines_s = CNT_W'(len_bytes >> OFF_W)
                      + ((len_bytes[OFF_W-1:0] != OFF_ZERO) ? CNT_ONE : CNT_ZERO);
        last_line_s   = (lines_q == CNT_ONE);
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_d        = state_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        ddr_req_d      = 1'b0;
        ddr_req_addr_d = 32'd0;
        sram_wr_d      = sram_wr_q;
        sram_wr_addr_d = sram_wr_addr_q;
        sram_wr_data_d = sram_wr_data_q;
        sram_wr_mask_d = sram_wr_mask_q;
        cur_ddr_d      = cur_ddr_q;
        cur_sram_d     = cur_sram_q;
        lines_d        = lines_q;
        rem_d          = rem_q;

        if (abort && (state_q != ST_IDLE)) begin
            // Abort beats any concurrent ddr_valid or sram_ack.
            state_d        = ST_IDLE;
            busy_d         = 1'b0;
            sram_wr_d      = 1'b0;
            sram_wr_addr_d = SADDR_ZERO;
            sram_wr_data_d = LINE_ZERO;
            sram_wr_mask_d = MASK_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cur_ddr_d  = ddr_addr;
                        cur_sram_d = sram_addr;
                        lines_d    = start_lines_s;
                        rem_d      = len_bytes[OFF_W-1:0];
                        if (len_bytes != LEN_ZERO) begin
                            state_d        = ST_REQ;
                            busy_d         = 1'b1;
                            ddr_req_d      = 1'b1;
                            ddr_req_addr_d = ddr_addr;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (ddr_valid) begin
                        state_d        = ST_WRITE;
                        sram_wr_d      = 1'b1;
                        sram_wr_addr_d = cur_sram_q;
                        sram_wr_data_d = ddr_data;
                        sram_wr_mask_d = last_line_s ? tail_mask(rem_q) : MASK_ONES;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WRITE: begin
                    if (sram_ack) begin
                        sram_wr_d      = 1'b0;
                        sram_wr_addr_d = SADDR_ZERO;
                        sram_wr_data_d = LINE_ZERO;
                        sram_wr_mask_d = MASK_ZERO;
                        if (last_line_s) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            // Address arithmetic wraps silently at the port width.
                            state_d        = ST_REQ;
                            cur_ddr_d      = cur_ddr_q + DDR_STEP;
                            cur_sram_d     = cur_sram_q + SRAM_STEP;
                            lines_d        = lines_q - CNT_ONE;
                            ddr_req_d      = 1'b1;
                            ddr_req_addr_d = cur_ddr_q + DDR_STEP;
                        end
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d        = ST_IDLE;
                    busy_d         = 1'b0;
                    sram_wr_d      = 1'b0;
                    sram_wr_addr_d = SADDR_ZERO;
                    sram_wr_data_d = LINE_ZERO;
                    sram_wr_mask_d = MASK_ZERO;
                end
            endcase
        end
    end

    // State, output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            ddr_req_q      <= 1'b0;
            ddr_req_addr_q <= 32'd0;
            sram_wr_q      <= 1'b0;
            sram_wr_addr_q <= SADDR_ZERO;
            sram_wr_data_q <= LINE_ZERO;
            sram_wr_mask_q <= MASK_ZERO;
            cur_ddr_q      <= 32'd0;
            cur_sram_q     <= SADDR_ZERO;
            lines_q        <= CNT_ZERO;
            rem_q          <= OFF_ZERO;
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            ddr_req_q      <= ddr_req_d;
            ddr_req_addr_q <= ddr_req_addr_d;
            sram_wr_q      <= sram_wr_d;
            sram_wr_addr_q <= sram_wr_addr_d;
            sram_wr_data_q <= sram_wr_data_d;
            sram_wr_mask_q <= sram_wr_mask_d;
            cur_ddr_q      <= cur_ddr_d;
            cur_sram_q     <= cur_sram_d;
            lines_q        <= lines_d;
            rem_q          <= rem_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign ddr_req      = ddr_req_q;
    assign ddr_req_addr = ddr_req_addr_q;
    assign sram_wr      = sram_wr_q;
    assign sram_wr_addr = sram_wr_addr_q;
    assign sram_wr_data = sram_wr_data_q;
    assign sram_wr_mask = sram_wr_mask_q;

endmodule

// File: tb/tb_mem_ddr_load_ctrl.sv
// Bench for mem_ddr_load_ctrl: directed transfers, a transaction-level
// reference model updated on each clock edge, a per-cycle compare process,
// and literal expectations on logged requests and writes.
module tb_mem_ddr_load_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [31:0]  ddr_addr;
    logic [18:0]  sram_addr;
    logic [15:0]  len_bytes;
    logic         abort;
    logic         busy, done, ddr_req, sram_wr;
    logic [31:0]  ddr_req_addr;
    logic         ddr_valid;
    logic [255:0] ddr_data;
    logic [18:0]  sram_wr_addr;
    logic [255:0] sram_wr_data;
    logic [31:0]  sram_wr_mask;
    logic         sram_ack;

    int checks = 0;
    int errors = 0;

    mem_ddr_load_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ddr_addr(ddr_addr),
        .sram_addr(sram_addr), .len_bytes(len_bytes), .abort(abort),
        .busy(busy), .done(done), .ddr_req(ddr_req), .ddr_req_addr(ddr_req_addr),
        .ddr_valid(ddr_valid), .ddr_data(ddr_data), .sram_wr(sram_wr),
        .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
        .sram_wr_mask(sram_wr_mask), .sram_ack(sram_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected outputs for the cycle following each edge.
    logic         m_busy = 1'b0, m_done = 1'b0, m_req = 1'b0, m_wr = 1'b0;
    logic [31:0]  m_req_addr = 32'd0;
    logic [18:0]  m_wr_addr = 19'd0;
    logic [255:0] m_wr_data = 256'd0;
    logic [31:0]  m_wr_mask = 32'd0;
    logic         m_active = 1'b0, m_wait = 1'b0;
    logic [31:0]  m_ddr_base = 32'd0;
    logic [18:0]  m_sram_base = 19'd0;
    int           m_len = 0, m_nlines = 0, m_li = 0;

    function automatic logic [31:0] line_ddr(input int i);
        return m_ddr_base + 32'(i) * 32'd32;
    endfunction

    function automatic logic [18:0] line_sram(input int i);
        logic [31:0] t;
        t = {13'd0, m_sram_base} + 32'(i) * 32'd32;
        return t[18:0];
    endfunction

    function automatic logic [31:0] line_mask(input int i);
        int rem;
        rem = m_len % 32;
        if (i != m_nlines - 1 || rem == 0) return 32'hFFFF_FFFF;
        else return (32'd1 << rem) - 32'd1;
    endfunction

    initial begin
        logic n_req, n_done;
        logic [31:0] n_req_addr;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 0; m_done = 0; m_req = 0; m_wr = 0; m_req_addr = 0;
                m_wr_addr = 0; m_wr_data = 0; m_wr_mask = 0; m_active = 0; m_wait = 0;
            end else begin
                n_req = 0; n_done = 0; n_req_addr = 0;
                if (abort && (m_active || m_done)) begin
                    m_active = 0; m_wait = 0; m_busy = 0; m_wr = 0;
                    m_wr_addr = 0; m_wr_data = 0; m_wr_mask = 0;
                end else if (!m_active && !m_done) begin
                    if (start) begin
                        m_ddr_base = ddr_addr; m_sram_base = sram_addr;
                        m_len = int'(len_bytes); m_nlines = (m_len + 31) / 32; m_li = 0;
                        if (m_len == 0) n_done = 1;
                        else begin
                            m_active = 1; m_busy = 1; n_req = 1; n_req_addr = line_ddr(0);
                        end
                    end
                end else if (m_active) begin
                    if (m_req) m_wait = 1;
                    else if (m_wait && ddr_valid) begin
                        m_wait = 0; m_wr = 1; m_wr_addr = line_sram(m_li);
                        m_wr_data = ddr_data; m_wr_mask = line_mask(m_li);
                    end else if (m_wr && sram_ack) begin
                        m_wr = 0; m_wr_addr = 0; m_wr_data = 0; m_wr_mask = 0;
                        m_li++;
                        if (m_li == m_nlines) begin
                            n_done = 1; m_busy = 0; m_active = 0;
                        end else begin
                            n_req = 1; n_req_addr = line_ddr(m_li);
                        end
                    end
                end
                m_req = n_req; m_req_addr = n_req_addr; m_done = n_done;
            end
        end
    end

    // ---------------- compare process and logging ----------------
    logic [31:0]  req_log[$];
    logic [18:0]  wr_addr_log[$];
    logic [31:0]  wr_mask_log[$];
    logic [255:0] wr_data_log[$];
    int           done_cnt = 0;
    logic         prev_wr = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                chk("busy", busy, m_busy);
                chk("done", done, m_done);
                chk("ddr_req", ddr_req, m_req);
                chk("ddr_req_addr", ddr_req_addr, m_req_addr);
                chk("sram_wr", sram_wr, m_wr);
                chk("sram_wr_addr", sram_wr_addr, m_wr_addr);
                chk("sram_wr_data", sram_wr_data, m_wr_data);
                chk("sram_wr_mask", sram_wr_mask, m_wr_mask);
                if (ddr_req) req_log.push_back(ddr_req_addr);
                if (sram_wr && !prev_wr) begin
                    wr_addr_log.push_back(sram_wr_addr);
                    wr_mask_log.push_back(sram_wr_mask);
                    wr_data_log.push_back(sram_wr_data);
                end
                if (done) done_cnt++;
                prev_wr = sram_wr;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_log.delete(); wr_addr_log.delete(); wr_mask_log.delete();
        wr_data_log.delete(); done_cnt = 0;
    endtask

    function automatic logic [255:0] mkdata(input int seed);
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = 32'hC0DE_0000 + 32'(seed * 8 + k);
        return d;
    endfunction

    task automatic do_start(input logic [31:0] d, input logic [18:0] s, input logic [15:0] l);
        ddr_addr = d; sram_addr = s; len_bytes = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_req();
        int i;
        i = 0;
        while (!ddr_req && i < 50) begin @(negedge clk); i++; end
        if (!ddr_req) begin errors++; checks++; $display("FAIL req_timeout at %0t", $time); end
    endtask

    task automatic give_valid(input int lat, input logic [255:0] d);
        repeat (lat) @(negedge clk);
        ddr_valid = 1'b1; ddr_data = d;
        @(negedge clk);
        ddr_valid = 1'b0;
    endtask

    task automatic wait_wr();
        int i;
        i = 0;
        while (!sram_wr && i < 50) begin @(negedge clk); i++; end
        if (!sram_wr) begin errors++; checks++; $display("FAIL wr_timeout at %0t", $time); end
    endtask

    task automatic give_ack(input int dly);
        repeat (dly) @(negedge clk);
        sram_ack = 1'b1;
        @(negedge clk);
        sram_ack = 1'b0;
    endtask

    task automatic run_line(input int lat, input int ackd, input logic [255:0] d);
        wait_req();
        give_valid(lat, d);
        wait_wr();
        give_ack(ackd);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; ddr_addr = 32'd0; sram_addr = 19'd0; len_bytes = 16'd0;
        abort = 1'b0; ddr_valid = 1'b0; ddr_data = 256'd0; sram_ack = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_req", ddr_req, 1'b0);
        chk("reset_wr", sram_wr, 1'b0);
        chk("reset_data", sram_wr_data, 256'd0);

        // len=64, two full lines, DDR latency 3, immediate ack
        clear_logs();
        do_start(32'h0000_1000, 19'h00040, 16'd64);
        run_line(3, 0, mkdata(1));
        run_line(3, 0, mkdata(2));
        idle(4);
        chk("t1_nreq", 256'(req_log.size()), 256'd2);
        chk("t1_req0", req_log[0], 32'h0000_1000);
        chk("t1_req1", req_log[1], 32'h0000_1020);
        chk("t1_wr0", wr_addr_log[0], 19'h00040);
        chk("t1_wr1", wr_addr_log[1], 19'h00060);
        chk("t1_mask1", wr_mask_log[1], 32'hFFFF_FFFF);
        chk("t1_data1", wr_data_log[1], mkdata(2));
        chk("t1_done", 256'(done_cnt), 256'd1);
        chk("t1_busy", busy, 1'b0);

        // len=40, partial last line, ack after 2
        clear_logs();
        do_start(32'h0000_2000, 19'h00100, 16'd40);
        run_line(1, 2, mkdata(3));
        run_line(2, 2, mkdata(4));
        idle(3);
        chk("t2_nwr", 256'(wr_addr_log.size()), 256'd2);
        chk("t2_mask0", wr_mask_log[0], 32'hFFFF_FFFF);
        chk("t2_mask1", wr_mask_log[1], 32'h0000_00FF);

        // abort while idle has no effect, then len=32 is a single full line
        abort = 1'b1; idle(1); abort = 1'b0;
        clear_logs();
        do_start(32'h0000_4000, 19'h00200, 16'd32);
        run_line(2, 0, mkdata(5));
        idle(3);
        chk("t3_nwr", 256'(wr_addr_log.size()), 256'd1);
        chk("t3_mask", wr_mask_log[0], 32'hFFFF_FFFF);
        chk("t3_done", 256'(done_cnt), 256'd1);

        // len=0: done on the cycle after start, no traffic
        clear_logs();
        do_start(32'h0000_5000, 19'h00300, 16'd0);
        #1;
        chk("t4_done_t1", done, 1'b1);
        idle(4);
        chk("t4_nreq", 256'(req_log.size()), 256'd0);
        chk("t4_nwr", 256'(wr_addr_log.size()), 256'd0);
        chk("t4_done", 256'(done_cnt), 256'd1);

        // ack held off 5 cycles on the first of two lines
        clear_logs();
        do_start(32'h0000_6000, 19'h00400, 16'd64);
        run_line(2, 5, mkdata(6));
        run_line(1, 1, mkdata(7));
        idle(3);
        chk("t5_nreq", 256'(req_log.size()), 256'd2);
        chk("t5_done", 256'(done_cnt), 256'd1);

        // abort in WAIT, late ddr_valid ignored, then a normal len=32
        clear_logs();
        do_start(32'h0000_7000, 19'h00500, 16'd64);
        wait_req();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; ddr_valid = 1'b1; ddr_data = mkdata(8);
        @(negedge clk);
        ddr_valid = 1'b0;
        idle(4);
        chk("t6_nwr", 256'(wr_addr_log.size()), 256'd0);
        chk("t6_done", 256'(done_cnt), 256'd0);
        chk("t6_busy", busy, 1'b0);
        do_start(32'h0000_7800, 19'h00600, 16'd32);
        run_line(2, 0, mkdata(9));
        idle(3);
        chk("t6_after_done", 256'(done_cnt), 256'd1);

        // address wrap on both sides
        clear_logs();
        do_start(32'hFFFF_FFE0, 19'h7FFE0, 16'd64);
        run_line(1, 0, mkdata(10));
        run_line(1, 0, mkdata(11));
        idle(3);
        chk("t7_req1", req_log[1], 32'h0000_0000);
        chk("t7_wr0", wr_addr_log[0], 19'h7FFE0);
        chk("t7_wr1", wr_addr_log[1], 19'h00000);

        // start pulsed while busy is ignored
        clear_logs();
        do_start(32'h0000_3000, 19'h00200, 16'd64);
        wait_req();
        do_start(32'h0000_9000, 19'h00700, 16'd0);
        give_valid(1, mkdata(12));
        wait_wr();
        give_ack(0);
        run_line(1, 0, mkdata(13));
        idle(3);
        chk("t8_nreq", 256'(req_log.size()), 256'd2);
        chk("t8_req1", req_log[1], 32'h0000_3020);
        chk("t8_done", 256'(done_cnt), 256'd1);

        // abort together with sram_ack: write stands, no done
        clear_logs();
        do_start(32'h0000_A000, 19'h00800, 16'd64);
        wait_req();
        give_valid(1, mkdata(14));
        wait_wr();
        abort = 1'b1; sram_ack = 1'b1;
        @(negedge clk);
        abort = 1'b0; sram_ack = 1'b0;
        idle(4);
        chk("t9_nwr", 256'(wr_addr_log.size()), 256'd1);
        chk("t9_nreq", 256'(req_log.size()), 256'd1);
        chk("t9_done", 256'(done_cnt), 256'd0);

        // abort together with ddr_valid: data dropped
        clear_logs();
        do_start(32'h0000_B000, 19'h00900, 16'd32);
        wait_req();
        @(negedge clk);
        abort = 1'b1; ddr_valid = 1'b1; ddr_data = mkdata(15);
        @(negedge clk);
        abort = 1'b0; ddr_valid = 1'b0;
        idle(4);
        chk("t10_nwr", 256'(wr_addr_log.size()), 256'd0);
        chk("t10_done", 256'(done_cnt), 256'd0);

        // reset while writing clears outputs immediately
        do_start(32'h0000_C000, 19'h00A00, 16'd32);
        wait_req();
        give_valid(2, mkdata(16));
        wait_wr();
        rst_n = 1'b0;
        #1;
        chk("t11_wr", sram_wr, 1'b0);
        chk("t11_busy", busy, 1'b0);
        chk("t11_data", sram_wr_data, 256'd0);
        chk("t11_mask", sram_wr_mask, 32'd0);
        chk("t11_addr", sram_wr_addr, 19'd0);
        idle(2);
        rst_n = 1'b1;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
